// File: rtl/param_add_acc_if.sv
// Operand/result handshake bundle for param_add_acc.
interface param_add_acc_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [1:0]       in_mode;
  logic             in_sat;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_carry;

  modport master (
    output in_valid, in_a, in_b, in_mode, in_sat, out_ready,
    input  in_ready, out_valid, out_sum, out_carry
  );

  modport slave (
    input  in_valid, in_a, in_b, in_mode, in_sat, out_ready,
    output in_ready, out_valid, out_sum, out_carry
  );
endinterface

// File: rtl/param_add_acc.sv
// Registered adder/accumulator with saturation option, overflow counter
// and a small result FIFO for consumer backpressure.
module param_add_acc #(
  parameter int WIDTH     = 4,
  parameter int DEPTH     = 2,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  param_add_acc_if.slave       bus,
  output logic [WIDTH-1:0]     acc_value,
  output logic [CNT_WIDTH-1:0] ovf_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    MODE_ADD = 2'b00,
    MODE_SUB = 2'b01,
    MODE_ACC = 2'b10,
    MODE_CLR = 2'b11
  } mode_e;

  logic [WIDTH-1:0] mem_sum   [DEPTH];
  logic             mem_carry [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;

  mode_e            mode;
  logic [WIDTH:0]   add_r;
  logic [WIDTH:0]   acc_r;
  logic [WIDTH-1:0] res_sum;
  logic             res_carry;
  logic             accept;
  logic             pop;

  assign mode = mode_e'(bus.in_mode);

  // Handshake: ready only when a FIFO slot is free; no pass-through when full.
  assign bus.in_ready  = ~reset & (count < CW'(DEPTH));
  assign bus.out_valid = (count != '0);
  assign bus.out_sum   = bus.out_valid ? mem_sum[rd_ptr]   : '0;
  assign bus.out_carry = bus.out_valid ? mem_carry[rd_ptr] : 1'b0;
  assign accept        = bus.in_valid & bus.in_ready;
  assign pop           = bus.out_valid & bus.out_ready;

  // Result datapath for the operation currently offered.
  always_comb begin
    add_r     = {1'b0, bus.in_a} + {1'b0, bus.in_b};
    acc_r     = {1'b0, acc_value} + {1'b0, bus.in_a};
    res_sum   = '0;
    res_carry = 1'b0;
    case (mode)
      MODE_ADD: begin
        res_carry = add_r[WIDTH];
        res_sum   = (bus.in_sat & res_carry) ? '1 : add_r[WIDTH-1:0];
      end
      MODE_SUB: begin
        res_carry = (bus.in_a < bus.in_b);
        res_sum   = (bus.in_sat & res_carry) ? '0 : (bus.in_a - bus.in_b);
      end
      MODE_ACC: begin
        res_carry = acc_r[WIDTH];
        res_sum   = (bus.in_sat & res_carry) ? '1 : acc_r[WIDTH-1:0];
      end
      MODE_CLR: begin
        res_sum   = '0;
        res_carry = 1'b0;
      end
    endcase
  end

  // FIFO pointers and occupancy; simultaneous push and pop keep occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + PW'(1);
      if (pop)    rd_ptr <= rd_ptr + PW'(1);
      case ({accept, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage; empty entries are masked at the output so no reset needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_sum[wr_ptr]   <= res_sum;
      mem_carry[wr_ptr] <= res_carry;
    end
  end

  // Accumulator register, touched only by accepted ACC/CLR.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_value <= '0;
    end else if (accept && mode == MODE_ACC) begin
      acc_value <= res_sum;
    end else if (accept && mode == MODE_CLR) begin
      acc_value <= '0;
    end
  end

  // Saturating count of accepted results carrying a carry/borrow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_count <= '0;
    end else if (accept && res_carry && (ovf_count != '1)) begin
      ovf_count <= ovf_count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_param_add_acc.sv
// Scoreboard bench for param_add_acc (WIDTH=4, DEPTH=2, CNT_WIDTH=8).
module tb_param_add_acc;

  localparam int M_ADD = 0;
  localparam int M_SUB = 1;
  localparam int M_ACC = 2;
  localparam int M_CLR = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] acc_value;
  logic [7:0] ovf_count;

  int total = 0;
  int bad   = 0;
  int q_sum[$];
  int q_carry[$];
  int m_acc  = 0;
  int m_ovf  = 0;
  int pushed = 0;
  int popped = 0;
  int mon_sum;
  int mon_carry;

  param_add_acc_if #(.WIDTH(4)) bus ();

  param_add_acc #(.WIDTH(4), .DEPTH(2), .CNT_WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .acc_value (acc_value),
    .ovf_count (ovf_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model of one operation, evaluated against the model accumulator.
  task automatic model(input int m, input int a, input int b, input int s,
                       output int sum, output int carry);
    int r;
    sum = 0;
    carry = 0;
    if (m == M_ADD || m == M_ACC) begin
      r = (m == M_ADD) ? a + b : m_acc + a;
      carry = (r > 15) ? 1 : 0;
      sum = (s != 0 && carry != 0) ? 15 : r % 16;
    end else if (m == M_SUB) begin
      carry = (a < b) ? 1 : 0;
      sum = (s != 0 && carry != 0) ? 0 : (a - b + 16) % 16;
    end
  endtask

  task automatic send(input int m, input int a, input int b, input int s);
    int waitc;
    int es;
    int ec;
    logic [31:0] mv;
    logic [31:0] av;
    logic [31:0] bv;
    mv = m;
    av = a;
    bv = b;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_mode  = mv[1:0];
    bus.in_a     = av[3:0];
    bus.in_b     = bv[3:0];
    bus.in_sat   = (s != 0);
    waitc = 0;
    while (bus.in_ready !== 1'b1 && waitc < 40) begin
      @(negedge clk);
      waitc++;
    end
    if (bus.in_ready !== 1'b1) begin
      check("accept_wait", bus.in_ready, 1);
      bus.in_valid = 1'b0;
      return;
    end
    model(m, a, b, s, es, ec);
    q_sum.push_back(es);
    q_carry.push_back(ec);
    pushed++;
    if (m == M_ACC) m_acc = es;
    if (m == M_CLR) m_acc = 0;
    if (ec != 0 && m_ovf < 255) m_ovf++;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int waitc;
    waitc = 0;
    while ((q_sum.size() != 0 || bus.out_valid !== 1'b0) && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    check("drain_done", q_sum.size(), 0);
  endtask

  // Output monitor: a beat taken at the next edge is compared with the scoreboard head.
  always @(negedge clk) begin
    if (reset === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (q_sum.size() == 0) begin
        check("extra_beat", 1, 0);
      end else begin
        mon_sum   = q_sum.pop_front();
        mon_carry = q_carry.pop_front();
        check("beat_sum", bus.out_sum, mon_sum);
        check("beat_carry", bus.out_carry, mon_carry);
        popped++;
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_mode   = '0;
    bus.in_sat    = 1'b0;
    bus.out_ready = 1'b1;
    #3;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_sum", bus.out_sum, 0);
    check("rst_out_carry", bus.out_carry, 0);
    check("rst_acc", acc_value, 0);
    check("rst_ovf", ovf_count, 0);
    check("rst_in_ready", bus.in_ready, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("in_ready_after_rst", bus.in_ready, 1);

    // ADD with latency-1 check
    send(M_ADD, 3, 4, 0);
    @(negedge clk);
    check("lat_out_valid", bus.out_valid, 1);
    check("lat_out_sum", bus.out_sum, 7);
    check("lat_out_carry", bus.out_carry, 0);
    check("lat_ovf", ovf_count, 0);
    drain();

    // ADD overflow wrap and saturate
    send(M_ADD, 9, 8, 0);
    send(M_ADD, 9, 8, 1);
    drain();
    check("ovf_after_add", ovf_count, m_ovf);
    check("ovf_after_add_abs", ovf_count, 2);

    // SUB borrow wrap / saturate / normal
    send(M_SUB, 2, 5, 0);
    send(M_SUB, 2, 5, 1);
    send(M_SUB, 5, 2, 0);
    drain();
    check("ovf_after_sub", ovf_count, m_ovf);

    // Accumulate with saturation, then clear
    send(M_ACC, 6, 0, 1);
    send(M_ACC, 7, 0, 1);
    send(M_ACC, 5, 0, 1);
    drain();
    check("acc_sat", acc_value, 15);
    check("acc_model", acc_value, m_acc);
    send(M_CLR, 4, 4, 0);
    @(negedge clk);
    check("acc_clr", acc_value, 0);
    drain();
    check("ovf_after_acc", ovf_count, m_ovf);

    // Backpressure: two fit, third waits until the consumer drains
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    send(M_ADD, 1, 1, 0);
    send(M_ADD, 2, 2, 0);
    @(negedge clk);
    check("full_in_ready", bus.in_ready, 0);
    check("full_head", bus.out_sum, 2);
    @(negedge clk);
    check("hold_head", bus.out_sum, 2);
    check("hold_valid", bus.out_valid, 1);
    fork
      send(M_ADD, 3, 3, 0);
      begin
        repeat (2) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    drain();

    // Reset mid-operation with full FIFO and non-zero accumulator
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    send(M_CLR, 0, 0, 0);
    send(M_ACC, 9, 0, 0);
    @(negedge clk);
    check("pre_rst_acc", acc_value, 9);
    check("pre_rst_full", bus.in_ready, 0);
    #2 reset = 1'b1;
    #1;
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_acc", acc_value, 0);
    check("midrst_ovf", ovf_count, 0);
    check("midrst_in_ready", bus.in_ready, 0);
    pushed = pushed - q_sum.size();
    q_sum.delete();
    q_carry.delete();
    m_acc = 0;
    m_ovf = 0;
    #3 reset = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", bus.in_ready, 1);
    check("post_rst_out_valid", bus.out_valid, 0);
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    send(M_ADD, 1, 2, 0);
    @(negedge clk);
    check("post_rst_sum", bus.out_sum, 3);
    drain();
    check("post_rst_ovf", ovf_count, m_ovf);
    check("all_popped", popped, pushed);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
